// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares a single-ported memory between the IFU and LSU.
// It issues one memory access per transaction and adds a programmable response latency.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_resp_data,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               wen_q, wen_d;
  logic               mem_valid_q, mem_valid_d;
  logic               mem_wen_q, mem_wen_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wmask_q, mem_wmask_d;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               ifu_resp_valid_q, ifu_resp_valid_d;
  logic [31:0]        ifu_resp_data_q, ifu_resp_data_d;
  logic               lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0]        lsu_resp_data_q, lsu_resp_data_d;

  logic               grant_ifu_s;
  logic               grant_lsu_s;
  logic               idle_s;
  logic [31:0]        rdata_sel_s;
  logic               resp_hs_s;

  // On a tie the LSU wins only if the IFU was served last.
  assign grant_lsu_s = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
  assign grant_ifu_s = ifu_req_valid && !grant_lsu_s;
  assign idle_s      = (state_q == ST_IDLE);

  // Gating with reset keeps the ready strobes low while reset is held.
  assign ifu_req_ready = idle_s && grant_ifu_s && reset;
  assign lsu_req_ready = idle_s && grant_lsu_s && reset;

  assign rdata_sel_s = wen_q ? 32'h0000_0000 : mem_rdata;
  assign resp_hs_s   = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    wen_d            = wen_q;
    mem_valid_d      = 1'b0;
    mem_wen_d        = 1'b0;
    mem_addr_d       = 32'h0000_0000;
    mem_wdata_d      = 32'h0000_0000;
    mem_wmask_d      = 4'h0;
    data_d           = data_q;
    cnt_d            = cnt_q;
    busy_d           = busy_q;
    ifu_resp_valid_d = ifu_resp_valid_q;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = lsu_resp_valid_q;
    lsu_resp_data_d  = lsu_resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_lsu_s) begin
          owner_d     = OWN_LSU;
          wen_d       = lsu_req_wen;
          mem_valid_d = 1'b1;
          mem_wen_d   = lsu_req_wen && (lsu_req_wmask != 4'h0);
          mem_addr_d  = lsu_req_addr;
          mem_wdata_d = lsu_req_wdata;
          mem_wmask_d = lsu_req_wmask;
          busy_d      = 1'b1;
          state_d     = ST_ACCESS;
        end else if (grant_ifu_s) begin
          owner_d     = OWN_IFU;
          wen_d       = 1'b0;
          mem_valid_d = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = ifu_req_addr;
          mem_wdata_d = 32'h0000_0000;
          mem_wmask_d = 4'h0;
          busy_d      = 1'b1;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        data_d = rdata_sel_s;
        cnt_d  = CNT_W'(LATENCY);
        if (LATENCY == 0) begin
          // No wait phase, so the response is loaded straight from the memory data.
          state_d          = ST_RESP;
          ifu_resp_valid_d = (owner_q == OWN_IFU);
          ifu_resp_data_d  = (owner_q == OWN_IFU) ? rdata_sel_s : 32'h0000_0000;
          lsu_resp_valid_d = (owner_q == OWN_LSU);
          lsu_resp_data_d  = (owner_q == OWN_LSU) ? rdata_sel_s : 32'h0000_0000;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d          = ST_RESP;
          ifu_resp_valid_d = (owner_q == OWN_IFU);
          ifu_resp_data_d  = (owner_q == OWN_IFU) ? data_q : 32'h0000_0000;
          lsu_resp_valid_d = (owner_q == OWN_LSU);
          lsu_resp_data_d  = (owner_q == OWN_LSU) ? data_q : 32'h0000_0000;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (resp_hs_s) begin
          last_grant_d     = owner_q;
          busy_d           = 1'b0;
          ifu_resp_valid_d = 1'b0;
          ifu_resp_data_d  = 32'h0000_0000;
          lsu_resp_valid_d = 1'b0;
          lsu_resp_data_d  = 32'h0000_0000;
          state_d          = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        busy_d           = 1'b0;
        ifu_resp_valid_d = 1'b0;
        ifu_resp_data_d  = 32'h0000_0000;
        lsu_resp_valid_d = 1'b0;
        lsu_resp_data_d  = 32'h0000_0000;
        state_d          = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_IFU;
      last_grant_q     <= OWN_LSU;
      wen_q            <= 1'b0;
      mem_valid_q      <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= 32'h0000_0000;
      mem_wdata_q      <= 32'h0000_0000;
      mem_wmask_q      <= 4'h0;
      data_q           <= 32'h0000_0000;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= 32'h0000_0000;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      wen_q            <= wen_d;
      mem_valid_q      <= mem_valid_d;
      mem_wen_q        <= mem_wen_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wmask_q      <= mem_wmask_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      busy_q           <= busy_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign busy           = busy_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=2 with a small word memory,
// one at LATENCY=0 whose memory returns the address XOR a fixed pattern.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
  logic [31:0] ifu_req_addr = 32'h0, ifu_resp_data;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0;
  logic [31:0] lsu_req_addr = 32'h0, lsu_req_wdata = 32'h0, lsu_resp_data;
  logic [3:0]  lsu_req_wmask = 4'h0;
  logic        lsu_resp_valid, lsu_resp_ready = 1'b0;
  logic        mem_valid, mem_wen, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        z_ifu_req_ready, z_ifu_resp_valid;
  logic [31:0] z_ifu_resp_data;
  logic        z_lsu_req_valid = 1'b0, z_lsu_req_ready, z_lsu_req_wen = 1'b0;
  logic [31:0] z_lsu_req_addr = 32'h0, z_lsu_req_wdata = 32'h0, z_lsu_resp_data;
  logic [3:0]  z_lsu_req_wmask = 4'h0;
  logic        z_lsu_resp_valid, z_lsu_resp_ready = 1'b0;
  logic        z_mem_valid, z_mem_wen, z_busy;
  logic [31:0] z_mem_addr, z_mem_wdata, z_mem_rdata;
  logic [3:0]  z_mem_wmask;

  logic [31:0] mem [0:63];
  int          pulses = 0;
  int          wr_pulses = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.LATENCY(2), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(0), .CNT_W(8)) u_zero (
    .clock(clock), .reset(reset),
    .ifu_req_valid(1'b0), .ifu_req_ready(z_ifu_req_ready), .ifu_req_addr(32'h0),
    .ifu_resp_valid(z_ifu_resp_valid), .ifu_resp_ready(1'b0), .ifu_resp_data(z_ifu_resp_data),
    .lsu_req_valid(z_lsu_req_valid), .lsu_req_ready(z_lsu_req_ready), .lsu_req_addr(z_lsu_req_addr),
    .lsu_req_wen(z_lsu_req_wen), .lsu_req_wdata(z_lsu_req_wdata), .lsu_req_wmask(z_lsu_req_wmask),
    .lsu_resp_valid(z_lsu_resp_valid), .lsu_resp_ready(z_lsu_resp_ready), .lsu_resp_data(z_lsu_resp_data),
    .mem_valid(z_mem_valid), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_wmask(z_mem_wmask), .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign z_mem_rdata = z_mem_addr ^ 32'hA5A5_A5A5;

  // Word memory: reloaded while reset is low, byte-masked writes on a write strobe.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_0413;
    end else if (mem_valid && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clock) begin
    if (mem_valid) pulses <= pulses + 1;
    if (mem_valid && mem_wen) wr_pulses <= wr_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction on the LATENCY=2 instance with the response taken at once.
  task automatic do_txn(input bit is_lsu, input logic [31:0] addr, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] exp_data);
    int lat;
    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_wen = wen;
      lsu_req_wdata = wdata; lsu_req_wmask = wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = addr;
    end
    #1;
    chk("req_ready", is_lsu ? lsu_req_ready : ifu_req_ready, 32'd1);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk("access_valid", mem_valid, 32'd1);
    chk("access_addr", mem_addr, addr);
    chk("access_wen", mem_wen, (wen && (wmask != 4'h0)) ? 32'd1 : 32'd0);
    lat = 1;
    while (((is_lsu ? lsu_resp_valid : ifu_resp_valid) !== 1'b1) && lat < 20) begin
      tick();
      lat++;
    end
    chk("resp_latency", lat, 32'd4);
    chk("resp_data", is_lsu ? lsu_resp_data : ifu_resp_data, exp_data);
    chk("other_resp_valid", is_lsu ? ifu_resp_valid : lsu_resp_valid, 32'd0);
    if (is_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    ifu_resp_ready = 1'b0;
    chk("busy_after_hs", busy, 32'd0);
    chk("resp_valid_after_hs", is_lsu ? lsu_resp_valid : ifu_resp_valid, 32'd0);
  endtask

  initial begin
    int p0, w0, n, both, rcnt;
    int g [0:3];

    // Reset: outputs stay low even with a request pending.
    ifu_req_valid = 1'b1;
    tick(); tick();
    chk("rst_ifu_ready", ifu_req_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_mem_valid", mem_valid, 32'd0);
    ifu_req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 32'd0);
    chk("post_rst_resp", ifu_resp_valid, 32'd0);
    chk("post_rst_data", ifu_resp_data, 32'd0);

    // Single IFU fetch.
    p0 = pulses;
    do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413);
    chk("fetch_pulses", pulses - p0, 32'd1);

    // LSU store then load of the same word.
    w0 = wr_pulses;
    do_txn(1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
    do_txn(1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF);
    chk("store_wr_pulses", wr_pulses - w0, 32'd1);

    // Zero-latency instance: load then mask-0 store.
    z_lsu_req_valid = 1'b1; z_lsu_req_addr = 32'h8000_0020; z_lsu_req_wen = 1'b0;
    #1;
    chk("z_ready", z_lsu_req_ready, 32'd1);
    tick();
    z_lsu_req_valid = 1'b0;
    chk("z_access", z_mem_valid, 32'd1);
    chk("z_access_addr", z_mem_addr, 32'h8000_0020);
    tick();
    chk("z_resp_valid", z_lsu_resp_valid, 32'd1);
    chk("z_resp_data", z_lsu_resp_data, 32'h25A5_A585);
    z_lsu_resp_ready = 1'b1;
    tick();
    z_lsu_resp_ready = 1'b0;
    z_lsu_req_valid = 1'b1; z_lsu_req_wen = 1'b1; z_lsu_req_wdata = 32'h1111_1111; z_lsu_req_wmask = 4'h0;
    #1;
    tick();
    z_lsu_req_valid = 1'b0;
    chk("z_mask0_valid", z_mem_valid, 32'd1);
    chk("z_mask0_wen", z_mem_wen, 32'd0);
    tick();
    chk("z_store_resp", z_lsu_resp_valid, 32'd1);
    chk("z_store_data", z_lsu_resp_data, 32'd0);
    z_lsu_resp_ready = 1'b1;
    tick();
    z_lsu_resp_ready = 1'b0;
    chk("z_busy_done", z_busy, 32'd0);
    chk("z_ifu_idle", z_ifu_resp_valid, 32'd0);

    // Both requesters continuously valid straight out of reset.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1'b0;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    #1;
    n = 0; both = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (ifu_req_ready && lsu_req_ready) both++;
      if (ifu_req_ready) begin g[n] = 0; n++; end
      else if (lsu_req_ready) begin g[n] = 1; n++; end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    chk("rr_count", n, 32'd4);
    chk("rr_g0", g[0], 32'd0);
    chk("rr_g1", g[1], 32'd1);
    chk("rr_g2", g[2], 32'd0);
    chk("rr_g3", g[3], 32'd1);
    chk("rr_both_ready", both, 32'd0);
    repeat (8) tick();
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    chk("rr_drained", busy, 32'd0);

    // Backpressure on the IFU response with an LSU request waiting.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    #1;
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1'b0;
    tick(); tick(); tick();
    p0 = pulses;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", ifu_resp_valid, 32'd1);
      chk("bp_data", ifu_resp_data, 32'h0000_0413);
      chk("bp_lsu_ready", lsu_req_ready, 32'd0);
      chk("bp_mem_valid", mem_valid, 32'd0);
      tick();
    end
    chk("bp_no_pulse", pulses - p0, 32'd0);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    chk("bp_released", ifu_resp_valid, 32'd0);
    chk("bp_lsu_next", lsu_req_ready, 32'd1);
    tick();
    lsu_req_valid = 1'b0;
    lsu_resp_ready = 1'b1;
    repeat (6) tick();
    lsu_resp_ready = 1'b0;
    chk("bp_drained", busy, 32'd0);

    // Reset during WAIT after an IFU grant, then a tie must still go to the IFU.
    do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413);
    p0 = pulses;
    ifu_req_valid = 1'b1;
    #1;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    chk("abort_busy_pre", busy, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 32'd0);
    chk("abort_mem_valid", mem_valid, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_resp", ifu_resp_valid, 32'd0);
    tick(); tick();
    reset = 1'b1;
    rcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (ifu_resp_valid || lsu_resp_valid) rcnt++;
      tick();
    end
    chk("abort_no_resp", rcnt, 32'd0);
    chk("abort_pulses", pulses - p0, 32'd1);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("abort_tie_ifu", ifu_req_ready, 32'd1);
    chk("abort_tie_lsu", lsu_req_ready, 32'd0);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    repeat (6) tick();
    ifu_resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbiter and sequencer that shares the single-ported DPI memory model between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block issues exactly one memory access per transaction and inserts a programmable latency to model a slow memory.
- Round-robin arbitration guarantees neither unit starves.

Parameters:
- LATENCY, 2, extra wait cycles between the memory access cycle and response-valid (0..255).
- CNT_W, 8, width of the latency counter; must hold LATENCY.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ifu_req_valid  input  1  IFU fetch request.
- ifu_req_ready  output  1  IFU request accepted this cycle when high together with valid.
- ifu_req_addr  input  32  fetch address.
- ifu_resp_valid  output  1  fetch data available.
- ifu_resp_ready  input  1  IFU consumes response.
- ifu_resp_data  output  32  fetched instruction word.
- lsu_req_valid  input  1  LSU load/store request.
- lsu_req_ready  output  1  LSU request accepted.
- lsu_req_addr  input  32  data address.
- lsu_req_wen  input  1  1 = store, 0 = load.
- lsu_req_wdata  input  32  store data.
- lsu_req_wmask  input  4  store byte mask.
- lsu_resp_valid  output  1  load data or store ack available.
- lsu_resp_ready  input  1  LSU consumes response.
- lsu_resp_data  output  32  load data (0 for stores).
- mem_valid  output  1  memory access strobe to the DPI memory wrapper.
- mem_wen  output  1  write enable.
- mem_addr  output  32  access address (used for read and write).
- mem_wdata  output  32  write data.
- mem_wmask  output  4  write byte mask.
- mem_rdata  input  32  combinational read data, valid in the same cycle as mem_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, latched addr/wdata/wmask/wen, data_q, cnt.
- Reset (reset = 0, async): state = IDLE; last_grant = LSU, so IFU wins the first tie; data_q = 0; cnt = 0.
  - All outputs are 0 during and after reset until a request arrives.
  - Reset mid-transaction aborts it. No memory access is replayed and no response is delivered.
- IDLE: grant is combinational.
  - Only one valid: grant that requester.
  - Both valid: grant the one not equal to last_grant.
  - The granted requester's req_ready = 1; the other's = 0. req_ready is 0 in every other state.
  - On valid && ready: latch the request and owner, then go to ACCESS. IFU requests latch wen = 0 and wmask = 0.
- ACCESS (exactly one cycle):
  - mem_valid = 1; mem_addr/mem_wdata/mem_wmask come from the latches.
  - mem_wen = latched wen && (wmask != 0). A store with mask 0 is performed as a no-op read.
  - data_q <= wen ? 0 : mem_rdata.
  - cnt <= LATENCY. Next state is WAIT if LATENCY > 0, else RESP.
- WAIT: cnt decrements each cycle. When cnt == 1, go to RESP.
- RESP:
  - The owner's resp_valid = 1 and resp_data = data_q, held stable until resp_ready.
  - The non-owner's resp_valid = 0.
  - On resp_ready: last_grant <= owner; go to IDLE.
  - resp_ready may be high before resp_valid; it is ignored outside RESP.
- Timing:
  - A request accepted in cycle t produces resp_valid first in cycle t+2+LATENCY.
  - The next request can be accepted in the cycle after the response handshake.
- The memory is written at most once per transaction: mem_valid is high for only one cycle per accept.
- mem_* outputs are 0 whenever mem_valid = 0.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Data outputs resp_data are 0 when the corresponding resp_valid = 0.

Test Plan:
- Single IFU fetch, LATENCY = 2, memory word at 0x80000000 = 0x00000413:
  - Request accepted in cycle 1; mem_valid pulses once in cycle 2.
  - ifu_resp_valid rises in cycle 5 with data 0x00000413.
  - busy drops after the handshake.
- LSU store to 0x80000010, wdata 0xDEADBEEF, wmask 0xF, then a load from the same address:
  - Exactly one write pulse occurs.
  - The store ack has data 0; the load returns 0xDEADBEEF.
- Both requesters valid continuously from reset:
  - Grants alternate IFU, LSU, IFU, LSU.
  - No requester is granted twice in a row.
- Backpressure: hold ifu_resp_ready = 0 for 10 cycles in RESP.
  - resp_valid and resp_data stay stable.
  - No new request is accepted and mem_valid stays 0.
- LATENCY = 0: resp_valid is asserted in cycle t+2.
  - A store with wmask = 0 produces mem_wen = 0.
- Assert reset during WAIT:
  - All outputs go to 0 immediately; state returns to IDLE.
  - No response is delivered and no second mem_valid pulse occurs.
  - The first post-reset tie is granted to IFU.
